// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron core scheduler.
package lif_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_ACC,
      S_LEAK,
      S_DONE
   } state_t;

   localparam int DEF_N        = 8;
   localparam int DEF_WEIGHT_W = 8;
   localparam int DEF_VMEM_W   = 16;

   typedef logic signed [DEF_VMEM_W-1:0]   vmem_t;
   typedef logic signed [DEF_WEIGHT_W-1:0] weight_t;

   // One guard bit catches overflow; clamp instead of wrapping.
   function automatic vmem_t sat_add(input vmem_t vmem, input weight_t weight);
      logic [DEF_VMEM_W:0] sum;
      sum = {vmem[DEF_VMEM_W-1], vmem}
          + {{(DEF_VMEM_W+1-DEF_WEIGHT_W){weight[DEF_WEIGHT_W-1]}}, weight};
      if (sum[DEF_VMEM_W] != sum[DEF_VMEM_W-1])
         sat_add = sum[DEF_VMEM_W] ? {1'b1, {(DEF_VMEM_W-1){1'b0}}}
                                   : {1'b0, {(DEF_VMEM_W-1){1'b1}}};
      else
         sat_add = sum[DEF_VMEM_W-1:0];
   endfunction

   function automatic vmem_t leak(input vmem_t vmem, input int shift);
      leak = vmem - (vmem >>> shift);
   endfunction

endpackage

// File: rtl/lif_vmem_bank.sv
// Membrane-potential register bank: async clear, one write port, two
// combinational read ports (datapath and debug).
module lif_vmem_bank #(
   parameter int N      = 8,
   parameter int IDX_W  = $clog2(N),
   parameter int VMEM_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [VMEM_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr_a,
   output logic [VMEM_W-1:0] o_rdata_a,
   input  logic [IDX_W-1:0]  i_raddr_b,
   output logic [VMEM_W-1:0] o_rdata_b
);

   logic [VMEM_W-1:0] r_mem [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cell
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
               r_mem[gi] <= '0;
            else if (i_we && (i_waddr == IDX_W'(gi)))
               r_mem[gi] <= i_wdata;
         end
      end
   endgenerate

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/lif_core_sched.sv
// LIF timestep scheduler: drains L1 spikes into membrane potentials one weight
// row at a time, then sweeps leak/threshold and pushes fired indices to L2.
module lif_core_sched
   import lif_pkg::*;
#(
   parameter int                       N          = DEF_N,
   parameter int                       IDX_W      = $clog2(N),
   parameter int                       SPIKE_W    = 8,
   parameter int                       WEIGHT_W   = DEF_WEIGHT_W,
   parameter int                       VMEM_W     = DEF_VMEM_W,
   parameter logic signed [VMEM_W-1:0] THRESH     = 16'sd32,
   parameter int                       LEAK_SHIFT = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_core,
   input  logic                 step_i,
   output logic                 busy_o,
   output logic                 done_o,
   input  logic                 in_empty_i,
   input  logic [SPIKE_W-1:0]   in_data_i,
   output logic                 in_rd_o,
   output logic [2*IDX_W-1:0]   w_addr_o,
   output logic                 w_rd_o,
   input  logic [WEIGHT_W-1:0]  w_data_i,
   input  logic                 out_full_i,
   output logic                 out_wr_o,
   output logic [SPIKE_W-1:0]   out_data_o,
   input  logic [IDX_W-1:0]     vmem_idx_i,
   output logic [VMEM_W-1:0]    vmem_o,
   output logic [7:0]           drop_cnt_o
);

   localparam logic [IDX_W:0] K_ONE  = (IDX_W+1)'(1);
   localparam logic [IDX_W:0] K_LAST = (IDX_W+1)'(N);
   localparam logic [IDX_W:0] J_LAST = (IDX_W+1)'(N-1);

   state_t r_state;
   state_t w_state_next;

   logic [IDX_W:0]           r_k;
   logic [IDX_W-1:0]         r_pre;
   logic [7:0]               r_drop;
   logic                     r_done;

   logic                     w_spike_ok;
   logic                     w_acc_rd;
   logic                     w_acc_we;
   logic                     w_fire;
   logic                     w_stall;
   logic                     w_we;
   logic [IDX_W-1:0]         w_j;
   logic [IDX_W-1:0]         w_dp_idx;
   logic [VMEM_W-1:0]        w_dp_vmem;
   logic [VMEM_W-1:0]        w_acc_sum;
   logic [VMEM_W-1:0]        w_wdata;
   logic signed [VMEM_W-1:0] w_leak_v;

   assign w_spike_ok = 32'(in_data_i) < 32'(N);
   assign w_j        = r_k[IDX_W-1:0];

   // ACC is one cycle deeper than the row: reads issue at k, writes land at k+1.
   assign w_acc_rd  = (r_state == S_ACC) && (r_k != K_LAST);
   assign w_acc_we  = (r_state == S_ACC) && (r_k != '0);
   assign w_dp_idx  = (r_state == S_ACC) ? IDX_W'(r_k - K_ONE) : w_j;
   assign w_acc_sum = sat_add(w_dp_vmem, w_data_i);

   assign w_leak_v = leak(w_dp_vmem, LEAK_SHIFT);
   assign w_fire   = (r_state == S_LEAK) && (w_leak_v >= THRESH);
   assign w_stall  = w_fire && out_full_i;
   assign w_we     = w_acc_we || ((r_state == S_LEAK) && !w_stall);
   assign w_wdata  = (r_state == S_ACC) ? w_acc_sum : (w_fire ? '0 : w_leak_v);

   assign busy_o     = (r_state != S_IDLE);
   assign done_o     = r_done;
   assign in_rd_o    = (r_state == S_POP) && !in_empty_i;
   assign w_rd_o     = w_acc_rd;
   assign w_addr_o   = w_acc_rd ? {r_pre, w_j} : '0;
   assign out_wr_o   = w_fire && !out_full_i;
   assign out_data_o = out_wr_o ? SPIKE_W'(w_j) : '0;
   assign drop_cnt_o = r_drop;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (step_i && en_core) w_state_next = S_POP;
         S_POP: begin
            if (in_empty_i)
               w_state_next = S_LEAK;
            else if (w_spike_ok)
               w_state_next = S_ACC;
         end
         S_ACC:  if (r_k == K_LAST) w_state_next = S_POP;
         S_LEAK: if (!w_stall && (r_k == J_LAST)) w_state_next = S_DONE;
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_k    <= '0;
         r_pre  <= '0;
         r_drop <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_POP: begin
               r_k <= '0;
               if (!in_empty_i) begin
                  r_pre <= in_data_i[IDX_W-1:0];
                  if (!w_spike_ok && (r_drop != 8'hFF))
                     r_drop <= r_drop + 8'd1;
               end
            end
            S_ACC:  r_k <= (r_k == K_LAST) ? '0 : r_k + K_ONE;
            // A blocked fire holds j so the same neuron is retried next cycle.
            S_LEAK: if (!w_stall) r_k <= (r_k == J_LAST) ? '0 : r_k + K_ONE;
            default: r_k <= '0;
         endcase
      end
   end

   lif_vmem_bank #(
      .N      (N),
      .IDX_W  (IDX_W),
      .VMEM_W (VMEM_W)
   ) u_bank (
      .i_clk     (clk_i),
      .i_rst     (rst_i),
      .i_we      (w_we),
      .i_waddr   (w_dp_idx),
      .i_wdata   (w_wdata),
      .i_raddr_a (w_dp_idx),
      .o_rdata_a (w_dp_vmem),
      .i_raddr_b (vmem_idx_i),
      .o_rdata_b (vmem_o)
   );

endmodule

// File: tb/tb_lif_core_sched.sv
// Randomized and directed bench for lif_core_sched against a timestep-level
// reference model (queue in, per-neuron arithmetic, expected push timeline).
module tb_lif_core_sched;

   localparam int N = 8, IDX_W = 3, SPIKE_W = 8, WEIGHT_W = 8, VMEM_W = 16;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic                en_core = 1'b0;
   logic                step_i = 1'b0;
   logic                busy_o, done_o, in_rd_o, w_rd_o, out_wr_o;
   logic                in_empty_i = 1'b1;
   logic [SPIKE_W-1:0]  in_data_i = '0;
   logic [2*IDX_W-1:0]  w_addr_o;
   logic [WEIGHT_W-1:0] w_data_i = '0;
   logic                out_full_i = 1'b0;
   logic [SPIKE_W-1:0]  out_data_o;
   logic [IDX_W-1:0]    vmem_idx_i = '0;
   logic [VMEM_W-1:0]   vmem_o;
   logic [7:0]          drop_cnt_o;

   int tests = 0;
   int fails = 0;

   logic [7:0] wmem [N*N];
   int         fifo[$];
   int         m_vmem [N];
   int         m_drop;

   logic               s_rd = 1'b0;
   logic               s_wrd = 1'b0;
   logic [2*IDX_W-1:0] s_waddr = '0;

   lif_core_sched dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_core(en_core), .step_i(step_i),
      .busy_o(busy_o), .done_o(done_o), .in_empty_i(in_empty_i),
      .in_data_i(in_data_i), .in_rd_o(in_rd_o), .w_addr_o(w_addr_o),
      .w_rd_o(w_rd_o), .w_data_i(w_data_i), .out_full_i(out_full_i),
      .out_wr_o(out_wr_o), .out_data_o(out_data_o), .vmem_idx_i(vmem_idx_i),
      .vmem_o(vmem_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // FWFT L1 queue and 1-cycle-latency weight memory models.
   always @(negedge clk_i) begin
      in_empty_i = (fifo.size() == 0);
      in_data_i  = (fifo.size() > 0) ? SPIKE_W'(fifo[0]) : '0;
      #1;
      s_rd    = in_rd_o;
      s_wrd   = w_rd_o;
      s_waddr = w_addr_o;
   end

   always @(posedge clk_i) begin
      if (s_rd && fifo.size() > 0) void'(fifo.pop_front());
      if (s_wrd) w_data_i <= wmem[s_waddr];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // v - floor(v / 8)
   function automatic int leak_model(input int v);
      int q;
      q = v / 8;
      if (v < 0 && (v % 8) != 0) q--;
      return v - q;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < N; k++) m_vmem[k] = 0;
      m_drop = 0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      #2;
      clear_model();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic check_vmem(input string tag);
      for (int k = 0; k < N; k++) begin
         @(negedge clk_i);
         vmem_idx_i = IDX_W'(k);
         #1;
         check($sformatf("%s_vmem%0d", tag, k), $signed(vmem_o), m_vmem[k]);
      end
   endtask

   task automatic run_step(input string tag, input int full_from, input int full_len,
                           input bit en_toggle);
      int exp_push[$], exp_cyc[$], got_push[$], got_cyc[$];
      int scyc, t, lv, exp_done, got_done, full_viol, extra_done, nspk;
      scyc = 0;
      nspk = fifo.size();
      foreach (fifo[i]) begin
         if (fifo[i] >= N) begin
            if (m_drop < 255) m_drop++;
            scyc += 1;
         end else begin
            for (int k = 0; k < N; k++)
               m_vmem[k] = sat16(m_vmem[k] + int'($signed(wmem[fifo[i]*N + k])));
            scyc += N + 2;
         end
      end
      t = scyc + 1;
      for (int j = 0; j < N; j++) begin
         lv = leak_model(m_vmem[j]);
         if (lv >= 32) begin
            while (t >= full_from && t < full_from + full_len) t++;
            exp_push.push_back(j);
            exp_cyc.push_back(t);
            m_vmem[j] = 0;
         end else begin
            m_vmem[j] = lv;
         end
         t++;
      end
      exp_done = t + 1;

      @(negedge clk_i);
      en_core = 1'b1;
      step_i  = 1'b1;
      @(posedge clk_i);
      got_done = -1;
      full_viol = 0;
      extra_done = 0;
      for (int c = 0; c < exp_done + 40; c++) begin
         @(negedge clk_i);
         step_i     = (c == 3);
         out_full_i = (c >= full_from && c < full_from + full_len);
         if (en_toggle) en_core = ((c % 5) < 2);
         #1;
         if (c == 0) check({tag, "_busy_start"}, busy_o, 1);
         if (out_wr_o) begin
            got_push.push_back(int'(out_data_o));
            got_cyc.push_back(c);
            if (out_full_i) full_viol++;
         end
         if (done_o) begin
            if (got_done < 0) got_done = c;
            else extra_done++;
         end
         if (got_done >= 0 && c == got_done + 1) begin
            check({tag, "_busy_end"}, busy_o, 0);
            break;
         end
      end
      step_i = 1'b0;
      out_full_i = 1'b0;
      en_core = 1'b1;

      check({tag, "_done_cyc"}, got_done, exp_done);
      check({tag, "_done_extra"}, extra_done, 0);
      check({tag, "_wr_when_full"}, full_viol, 0);
      check({tag, "_npush"}, got_push.size(), exp_push.size());
      for (int i = 0; i < got_push.size() && i < exp_push.size(); i++) begin
         check($sformatf("%s_push%0d_idx", tag, i), got_push[i], exp_push[i]);
         check($sformatf("%s_push%0d_cyc", tag, i), got_cyc[i], exp_cyc[i]);
      end
      check({tag, "_drop"}, drop_cnt_o, m_drop);
      check({tag, "_fifo_left"}, fifo.size(), 0);
      check_vmem(tag);
      $display("[TB] step %s: spikes=%0d done@%0d pushes=%0d drop=%0d",
               tag, nspk, got_done, got_push.size(), drop_cnt_o);
   endtask

   task automatic reset_mid_acc();
      fifo.push_back(3);
      @(negedge clk_i);
      en_core = 1'b1;
      step_i  = 1'b1;
      @(negedge clk_i);
      step_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      check("midacc_in_acc", w_rd_o, 1);
      #2;
      rst_i = 1'b1;
      #1;
      check("midacc_busy", busy_o, 0);
      check("midacc_done", done_o, 0);
      check("midacc_in_rd", in_rd_o, 0);
      check("midacc_w_rd", w_rd_o, 0);
      check("midacc_w_addr", w_addr_o, 0);
      check("midacc_out_wr", out_wr_o, 0);
      check("midacc_out_data", out_data_o, 0);
      check("midacc_drop", drop_cnt_o, 0);
      for (int k = 0; k < N; k++) begin
         vmem_idx_i = IDX_W'(k);
         #1;
         check($sformatf("midacc_vmem%0d", k), vmem_o, 0);
      end
      clear_model();
      @(negedge clk_i);
      rst_i = 1'b0;
      $display("[TB] step midacc_reset: aborted in ACC");
   endtask

   initial begin
      clear_model();
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_in_rd", in_rd_o, 0);
      check("rst_w_rd", w_rd_o, 0);
      check("rst_w_addr", w_addr_o, 0);
      check("rst_out_wr", out_wr_o, 0);
      check("rst_out_data", out_data_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // step_i with the core disabled must not start a timestep
      @(negedge clk_i);
      step_i = 1'b1;
      @(negedge clk_i);
      step_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      check("en_low_busy", busy_o, 0);

      for (int a = 0; a < N; a++)
         for (int b = 0; b < N; b++)
            wmem[a*N + b] = (a == b) ? 8'h10 : 8'h05;

      run_step("empty", 0, 0, 1'b0);

      fifo.push_back(3);
      run_step("one", 0, 0, 1'b0);
      vmem_idx_i = 3'd3;
      #1;
      check("one_vmem3_const", $signed(vmem_o), 14);

      do_reset();
      repeat (4) fifo.push_back(2);
      run_step("fire", 0, 0, 1'b0);

      do_reset();
      for (int s = 1; s <= 8; s++) fifo.push_back(s);
      run_step("drop1", 0, 0, 1'b0);
      check("drop1_const", drop_cnt_o, 1);

      reset_mid_acc();
      run_step("post_rst", 0, 0, 1'b0);

      do_reset();
      repeat (4) fifo.push_back(2);
      run_step("stall", 43, 5, 1'b0);

      do_reset();
      for (int b = 0; b < N; b++) wmem[b] = 8'h80;
      repeat (300) fifo.push_back(0);
      run_step("sat", 0, 0, 1'b1);

      repeat (260) fifo.push_back(200);
      run_step("dropsat", 0, 0, 1'b0);
      check("dropsat_const", drop_cnt_o, 255);

      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < N*N; a++)
            wmem[a] = 8'($urandom_range(0, 120) - 30);
         repeat ($urandom_range(0, 6)) fifo.push_back($urandom_range(0, N + 3));
         run_step($sformatf("rnd%0d", r), $urandom_range(0, 60), $urandom_range(0, 6),
                  1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
